// File: rtl/frv_mem_pkg.sv
// Shared constants and state encoding for the FRV memory initiator bridge.
package frv_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // One transaction in flight: capture, request, wait for response, hand back.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/frv_mem_initiator_if.sv
// BRAM-style slave port plus FRV request/response channel of the initiator bridge.
// master = the bridge itself; slave = its environment (BRAM master and FRV responder).
interface frv_mem_initiator_if;
  import frv_mem_pkg::*;

  // BRAM-style side
  logic              bram_cen;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [STRB_W-1:0] bram_wstrb;
  logic              bram_stall;
  logic [DATA_W-1:0] bram_rdata;
  logic              bram_error;

  // FRV memory channel side
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_wen;
  logic [STRB_W-1:0] mem_strb;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_recv;
  logic              mem_ack;
  logic              mem_error;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  bram_cen, bram_addr, bram_wdata, bram_wstrb,
    output bram_stall, bram_rdata, bram_error,
    output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
    input  mem_gnt, mem_recv, mem_error, mem_rdata
  );

  modport slave (
    output bram_cen, bram_addr, bram_wdata, bram_wstrb,
    input  bram_stall, bram_rdata, bram_error,
    input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
    output mem_gnt, mem_recv, mem_error, mem_rdata
  );

endinterface

// File: rtl/frv_mem_initiator.sv
// Bridge from a BRAM-style slave port to one FRV request/response transaction
// per access. Only one transaction is ever in flight; the BRAM master is
// stalled until the FRV response is back, then the result is handed over.
module frv_mem_initiator
  import frv_mem_pkg::*;
(
  input  logic                 g_clk,
  input  logic                 g_resetn,
  frv_mem_initiator_if.master  bus
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] bram_rdata_q;
  logic              bram_error_q;

  logic capture_req;
  logic capture_rsp;
  logic accept;

  // Next state, handshake outputs and stall; stall depends on state and bram_cen only.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d        = state_q;
    bus.bram_stall = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_ack    = 1'b0;
    capture_req    = 1'b0;
    capture_rsp    = 1'b0;
    accept         = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.bram_stall = bus.bram_cen;
        if (bus.bram_cen) begin
          capture_req = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        bus.bram_stall = 1'b1;
        bus.mem_req    = 1'b1;
        if (bus.mem_gnt) state_d = S_RESP;
      end
      S_RESP: begin
        bus.bram_stall = 1'b1;
        bus.mem_ack    = 1'b1;
        if (bus.mem_recv) begin
          capture_rsp = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // A dropped bram_cen here means the master abandoned; the result is discarded.
        accept  = bus.bram_cen;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops any in-flight FRV transaction.
  always_ff @(posedge g_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!g_resetn) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Request registers: captured once in IDLE, held stable through REQ until grant.
  always_ff @(posedge g_clk) begin
    // NOTE: datapath registers are reset too, since their reset values are visible on mem_* outputs.
    if (!g_resetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (capture_req) begin
      addr_q  <= bus.bram_addr;
      wdata_q <= bus.bram_wdata;
      strb_q  <= bus.bram_wstrb;
    end
  end

  // Response registers: sampled only in RESP, so unsolicited responses are ignored.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (capture_rsp) begin
      rdata_q <= bus.mem_rdata;
      err_q   <= bus.mem_error;
    end
  end

  // BRAM-side result: updated only when DONE is accepted, otherwise held.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      bram_rdata_q <= '0;
      bram_error_q <= 1'b0;
    end else if (accept) begin
      bram_rdata_q <= rdata_q;
      bram_error_q <= err_q;
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_strb   = strb_q;
  assign bus.mem_wen    = |strb_q;
  assign bus.bram_rdata = bram_rdata_q;
  assign bus.bram_error = bram_error_q;

endmodule

// File: tb/tb_frv_mem_initiator.sv
// Self-checking bench for frv_mem_initiator: behavioural FRV responder,
// directed vector table, hand-written corner sequences and random accesses
// checked against a word-level memory model.
module tb_frv_mem_initiator;
  import frv_mem_pkg::*;

  localparam int LAT_LIMIT = 40;

  logic g_clk    = 1'b0;
  logic g_resetn = 1'b0;

  frv_mem_initiator_if bif();

  frv_mem_initiator dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bif)
  );

  always #5 g_clk = ~g_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- Behavioural FRV responder ----------------
  int          rsp_gnt_dly  = 0;
  int          rsp_recv_dly = 0;
  bit          rsp_inject   = 1'b0;
  logic [31:0] resp_mem [256];

  initial begin
    bit          busy;
    int          cnt;
    logic [31:0] rd_v;
    logic        er_v;
    logic [7:0]  idx;
    busy = 1'b0; cnt = 0; rd_v = '0; er_v = 1'b0;
    bif.mem_gnt = 1'b0; bif.mem_recv = 1'b0; bif.mem_error = 1'b0; bif.mem_rdata = 32'h0BAD0BAD;
    forever begin
      @(negedge g_clk);
      #1;
      bif.mem_gnt = 1'b0; bif.mem_recv = 1'b0; bif.mem_error = 1'b0; bif.mem_rdata = 32'h0BAD0BAD;
      if (!g_resetn) begin
        busy = 1'b0; cnt = 0;
      end else if (rsp_inject) begin
        bif.mem_recv = 1'b1; bif.mem_error = 1'b1; bif.mem_rdata = 32'h5A5A5A5A;
      end else if (!busy) begin
        if (bif.mem_req) begin
          if (cnt >= rsp_gnt_dly) begin
            bif.mem_gnt = 1'b1; busy = 1'b1; cnt = 0;
            if (bif.mem_addr[31]) begin
              er_v = 1'b1; rd_v = 32'hCAFE0000;
            end else begin
              idx = bif.mem_addr[9:2];
              for (int b = 0; b < 4; b++)
                if (bif.mem_wen && bif.mem_strb[b]) resp_mem[idx][8*b +: 8] = bif.mem_wdata[8*b +: 8];
              er_v = 1'b0; rd_v = resp_mem[idx];
            end
          end else cnt++;
        end
      end else begin
        if (cnt >= rsp_recv_dly && bif.mem_ack) begin
          bif.mem_recv = 1'b1; bif.mem_error = er_v; bif.mem_rdata = rd_v;
          busy = 1'b0; cnt = 0;
        end else cnt++;
      end
    end
  end

  // ---------------- Reference model (word-addressed memory) ----------------
  logic [31:0] ref_mem [256];

  function automatic void ref_apply(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                                    output logic [31:0] rd, output logic er);
    logic [31:0] w;
    if (a[31]) begin
      rd = 32'hCAFE0000; er = 1'b1;
    end else begin
      w = ref_mem[a[9:2]];
      for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[a[9:2]] = w; rd = w; er = 1'b0;
    end
  endfunction

  // ---------------- Access drivers ----------------
  task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                            input int gd, input int rd, input bit scramble,
                            output logic [31:0] got_rdata, output logic got_err, output int lat);
    rsp_gnt_dly = gd; rsp_recv_dly = rd;
    @(negedge g_clk);
    bif.bram_cen = 1'b1; bif.bram_addr = a; bif.bram_wdata = wd; bif.bram_wstrb = st;
    lat = 0;
    #2;
    while (bif.bram_stall && lat < LAT_LIMIT) begin
      @(negedge g_clk);
      lat++;
      if (scramble) begin
        bif.bram_addr = $urandom; bif.bram_wdata = $urandom; bif.bram_wstrb = 4'($urandom);
      end
      #2;
    end
    @(negedge g_clk);
    got_rdata = bif.bram_rdata; got_err = bif.bram_error;
    bif.bram_cen = 1'b0;
  endtask

  logic        tr_stall [16];
  logic        tr_req   [16];
  logic        tr_ack   [16];
  logic        tr_wen   [16];
  logic        tr_err   [16];
  logic [3:0]  tr_strb  [16];
  logic [31:0] tr_addr  [16];
  logic [31:0] tr_wdata [16];
  logic [31:0] tr_rdata [16];

  task automatic trace_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                              input int gd, input int rd, input int ncyc);
    bit acc = 1'b0;
    rsp_gnt_dly = gd; rsp_recv_dly = rd;
    @(negedge g_clk);
    bif.bram_cen = 1'b1; bif.bram_addr = a; bif.bram_wdata = wd; bif.bram_wstrb = st;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) @(negedge g_clk);
      if (acc) bif.bram_cen = 1'b0;
      #2;
      tr_stall[k] = bif.bram_stall; tr_req[k] = bif.mem_req; tr_ack[k] = bif.mem_ack;
      tr_wen[k] = bif.mem_wen; tr_strb[k] = bif.mem_strb; tr_addr[k] = bif.mem_addr;
      tr_wdata[k] = bif.mem_wdata; tr_rdata[k] = bif.bram_rdata; tr_err[k] = bif.bram_error;
      if (bif.bram_cen && !bif.bram_stall) acc = 1'b1;
    end
    bif.bram_cen = 1'b0;
  endtask

  // ---------------- Directed vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          gd;
    int          rd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_exp  [3];

  initial begin
    logic [31:0] m_rd, got;
    logic        m_er, got_e;
    int          lat, nreq, b2b_got, acc_at;
    bit          pend;
    logic [3:0]  exp_stall, exp_req, exp_ack;

    vecs[0] = '{32'h0000_0020, 32'h0,         4'b0000, 0, 2, 32'hAA22CC44, 1'b0, 5};
    vecs[1] = '{32'h8000_0000, 32'h0,         4'b0000, 1, 1, 32'hCAFE0000, 1'b1, 5};
    vecs[2] = '{32'h0000_0100, 32'h0,         4'b0000, 0, 0, 32'hDEADBEEF, 1'b0, 3};
    vecs[3] = '{32'h8000_0010, 32'hFFFFFFFF, 4'b1111, 0, 0, 32'hCAFE0000, 1'b1, 3};
    vecs[4] = '{32'h0000_0104, 32'h0,         4'b0000, 2, 3, 32'h01234567, 1'b0, 8};
    vecs[5] = '{32'h0000_0104, 32'hFF000000, 4'b1000, 0, 1, 32'hFF234567, 1'b0, 4};
    vecs[6] = '{32'h0000_0104, 32'h0,         4'b0000, 1, 0, 32'hFF234567, 1'b0, 4};

    for (int i = 0; i < 256; i++) resp_mem[i] = 32'hF000_0000 | 32'(i);
    resp_mem[64] = 32'hDEADBEEF; resp_mem[8] = 32'hAABBCCDD; resp_mem[65] = 32'h01234567;
    resp_mem[0]  = 32'h10101010; resp_mem[1] = 32'h20202020; resp_mem[2]  = 32'h30303030;
    for (int i = 0; i < 256; i++) ref_mem[i] = resp_mem[i];

    bif.bram_cen = 1'b0; bif.bram_addr = '0; bif.bram_wdata = '0; bif.bram_wstrb = '0;

    // Reset state
    repeat (3) @(negedge g_clk);
    #2;
    check("reset_stall", 32'(bif.bram_stall), 32'd0);
    check("reset_mem_req", 32'(bif.mem_req), 32'd0);
    check("reset_mem_ack", 32'(bif.mem_ack), 32'd0);
    check("reset_rdata", bif.bram_rdata, 32'd0);
    check("reset_error", 32'(bif.bram_error), 32'd0);
    check("reset_mem_addr", bif.mem_addr, 32'd0);
    g_resetn = 1'b1;

    // Zero-wait read, cycle by cycle
    exp_stall = 4'b0111; exp_req = 4'b0010; exp_ack = 4'b0100;
    ref_apply(32'h100, 32'h0, 4'b0000, m_rd, m_er);
    trace_access(32'h100, 32'h0, 4'b0000, 0, 0, 6);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("zw_stall_c%0d", k), 32'(tr_stall[k]), 32'(exp_stall[k]));
      check($sformatf("zw_req_c%0d", k), 32'(tr_req[k]), 32'(exp_req[k]));
      check($sformatf("zw_ack_c%0d", k), 32'(tr_ack[k]), 32'(exp_ack[k]));
    end
    check("zw_rdata_c4", tr_rdata[4], 32'hDEADBEEF);
    check("zw_error_c4", 32'(tr_err[4]), 32'd0);

    // Write with grant delayed 3 cycles: request held 4 cycles, fields stable
    ref_apply(32'h20, 32'h11223344, 4'b0101, m_rd, m_er);
    trace_access(32'h20, 32'h11223344, 4'b0101, 3, 0, 9);
    nreq = 0;
    for (int k = 0; k < 9; k++) begin
      if (tr_req[k]) begin
        nreq++;
        check($sformatf("wr_addr_c%0d", k), tr_addr[k], 32'h20);
        check($sformatf("wr_wdata_c%0d", k), tr_wdata[k], 32'h11223344);
        check($sformatf("wr_strb_c%0d", k), 32'(tr_strb[k]), 32'h5);
        check($sformatf("wr_wen_c%0d", k), 32'(tr_wen[k]), 32'd1);
      end
    end
    check("wr_req_cycles", 32'(nreq), 32'd4);
    check("wr_accept_c6", 32'(tr_stall[6]), 32'd0);
    check("wr_rdata_c7", tr_rdata[7], m_rd);
    check("wr_memory_word", resp_mem[8], 32'hAA22CC44);

    // Vector table
    for (int v = 0; v < 7; v++) begin
      ref_apply(vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, m_rd, m_er);
      run_access(vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, vecs[v].gd, vecs[v].rd, 1'b0, got, got_e, lat);
      check($sformatf("vec%0d_rdata", v), got, vecs[v].exp_rdata);
      check($sformatf("vec%0d_error", v), 32'(got_e), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
    end

    // Abandon in DONE: no acceptance, previous result held
    rsp_gnt_dly = 0; rsp_recv_dly = 0;
    @(negedge g_clk);
    bif.bram_cen = 1'b1; bif.bram_addr = 32'h0; bif.bram_wstrb = 4'b0000;
    repeat (3) @(negedge g_clk);
    #2;
    check("abandon_done_stall", 32'(bif.bram_stall), 32'd0);
    bif.bram_cen = 1'b0;
    @(negedge g_clk);
    #2;
    check("abandon_rdata_held", bif.bram_rdata, 32'hFF234567);
    check("abandon_mem_req", 32'(bif.mem_req), 32'd0);
    check("abandon_mem_ack", 32'(bif.mem_ack), 32'd0);
    ref_apply(32'h4, 32'h0, 4'b0000, m_rd, m_er);
    run_access(32'h4, 32'h0, 4'b0000, 0, 0, 1'b0, got, got_e, lat);
    check("after_abandon_rdata", got, 32'h20202020);
    check("after_abandon_latency", 32'(lat), 32'd3);

    // Reset while waiting in RESP, then an unsolicited response
    rsp_gnt_dly = 0; rsp_recv_dly = 5;
    @(negedge g_clk);
    bif.bram_cen = 1'b1; bif.bram_addr = 32'h8; bif.bram_wstrb = 4'b0000;
    repeat (2) @(negedge g_clk);
    #2;
    check("rst_in_resp_ack", 32'(bif.mem_ack), 32'd1);
    g_resetn = 1'b0; bif.bram_cen = 1'b0;
    @(negedge g_clk);
    #2;
    check("rst_mem_ack", 32'(bif.mem_ack), 32'd0);
    check("rst_mem_req", 32'(bif.mem_req), 32'd0);
    check("rst_rdata", bif.bram_rdata, 32'd0);
    check("rst_error", 32'(bif.bram_error), 32'd0);
    g_resetn = 1'b1;
    @(negedge g_clk);
    rsp_inject = 1'b1;
    #2;
    check("unsolicited_ack", 32'(bif.mem_ack), 32'd0);
    @(negedge g_clk);
    rsp_inject = 1'b0;
    #2;
    check("unsolicited_rdata", bif.bram_rdata, 32'd0);
    check("unsolicited_stall", 32'(bif.bram_stall), 32'd0);
    ref_apply(32'h8, 32'h0, 4'b0000, m_rd, m_er);
    run_access(32'h8, 32'h0, 4'b0000, 0, 0, 1'b0, got, got_e, lat);
    check("after_reset_rdata", got, 32'h30303030);
    check("after_reset_latency", 32'(lat), 32'd3);

    // Back-to-back reads with bram_cen held
    b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4; b2b_addr[2] = 32'h8;
    b2b_exp[0] = 32'h10101010; b2b_exp[1] = 32'h20202020; b2b_exp[2] = 32'h30303030;
    rsp_gnt_dly = 0; rsp_recv_dly = 0;
    b2b_got = 0; pend = 1'b0; acc_at = 0;
    @(negedge g_clk);
    bif.bram_cen = 1'b1; bif.bram_addr = b2b_addr[0]; bif.bram_wstrb = 4'b0000;
    for (int cyc = 0; cyc < LAT_LIMIT && b2b_got < 3; cyc++) begin
      if (cyc > 0) @(negedge g_clk);
      if (pend) begin
        check($sformatf("b2b%0d_rdata", b2b_got), bif.bram_rdata, b2b_exp[b2b_got]);
        check($sformatf("b2b%0d_accept_cycle", b2b_got), 32'(acc_at), 32'(3 + 4 * b2b_got));
        b2b_got++;
        pend = 1'b0;
        if (b2b_got < 3) bif.bram_addr = b2b_addr[b2b_got];
        else             bif.bram_cen = 1'b0;
      end
      #2;
      if (bif.bram_cen && !bif.bram_stall) begin
        acc_at = cyc; pend = 1'b1;
      end
    end
    bif.bram_cen = 1'b0;
    check("b2b_results", 32'(b2b_got), 32'd3);

    // Random accesses against the memory model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, wd;
      logic [3:0]  st;
      int          gd, rd;
      a  = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      st = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      wd = $urandom;
      gd = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      ref_apply(a, wd, st, m_rd, m_er);
      run_access(a, wd, st, gd, rd, 1'b1, got, got_e, lat);
      check($sformatf("rnd%0d_rdata", i), got, m_rd);
      check($sformatf("rnd%0d_error", i), 32'(got_e), 32'(m_er));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(3 + gd + rd));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Time limit so a hung handshake still ends the run
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d miscompares of %0d, required completion", n_bad, n_vec);
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/frv_mem_initiator.md
# frv_mem_initiator

Bridge that presents a simple BRAM-style slave port and turns each access into one transaction on the FRV core's request/response memory channel. It is the initiator counterpart of the FRV BRAM adapter, so BRAM-style masters can reach any FRV-protocol responder: debug loaders, test DMA, or the adapter itself in loopback benches. It keeps at most one transaction in flight. It stalls the BRAM side until the FRV response has arrived.

## Interface
Parameters: none (address/data fixed at 32 bits, strobe 4 bits).

Ports:
- g_clk  in  1  clock; all state updates on rising edge
- g_resetn  in  1  reset, synchronous, active-low
- bram_cen  in  1  BRAM-side access request
- bram_addr  in  32  access address
- bram_wdata  in  32  write data
- bram_wstrb  in  4  byte write strobes; 4'b0000 = read
- bram_stall  out  1  access not accepted this cycle
- bram_rdata  out  32  read data, valid cycle after acceptance
- bram_error  out  1  error flag for the accepted access, same timing as bram_rdata
- mem_req  out  1  FRV request valid
- mem_gnt  in  1  FRV request accepted
- mem_wen  out  1  write enable (= |wstrb of captured access)
- mem_strb  out  4  write strobe
- mem_wdata  out  32  write data
- mem_addr  out  32  address
- mem_recv  in  1  FRV response valid
- mem_ack  out  1  FRV response accepted
- mem_error  in  1  response error
- mem_rdata  in  32  response data

## Operation
- **FSM states:** IDLE, REQ, RESP, DONE.
- **IDLE:**
  - bram_stall = bram_cen (combinational).
  - On bram_cen, capture addr/wdata/wstrb into request registers and go to REQ.
- **REQ:**
  - mem_req = 1. mem_addr/mem_wdata/mem_strb/mem_wen are driven from the registers and held stable until grant.
  - On mem_gnt, go to RESP.
  - bram_stall = 1.
- **RESP:**
  - mem_ack = 1.
  - On mem_recv, capture mem_rdata → rdata_q and mem_error → err_q, then go to DONE.
  - bram_stall = 1.
- **DONE:**
  - bram_stall = 0.
  - If bram_cen, the access is accepted. bram_rdata/bram_error present rdata_q/err_q from the next cycle. Go to IDLE.
  - If bram_cen is low (master abandoned), discard the result and go to IDLE.
- **BRAM master rule:** hold bram_cen and all request fields stable while bram_stall = 1. Changed fields during a stall are ignored; the captured values win.
- **Outputs outside their states:** mem_req = 0 outside REQ; mem_ack = 0 outside RESP.
- **Unsolicited responses:** a mem_recv arriving outside RESP is ignored and not acked.
- **Errors:** mem_error is forwarded, never generated. Writes also return rdata_q (whatever the responder drove).
- **Reset values:** state IDLE, mem_req 0, mem_ack 0, bram_rdata 0, bram_error 0, request registers 0.
- **Reset mid-operation:** any state returns to IDLE and the in-flight FRV transaction is dropped. The responder is reset with the same g_resetn.

## Timing
- **Minimum latency** against a zero-wait responder (gnt same cycle as req, recv the next cycle):
  - cycle 0: cen, stall, capture
  - cycle 1: REQ, gnt
  - cycle 2: RESP, recv, ack
  - cycle 3: DONE, stall = 0, accepted
  - cycle 4: bram_rdata valid
- **Extra latency:** each extra cycle of gnt or recv delay adds one cycle.
- **bram_rdata/bram_error:** updated only on a DONE acceptance; otherwise hold their last value.
- **Same-cycle gnt and recv:** mem_gnt and mem_recv both high in REQ is not legal for this responder; recv is sampled only in RESP.
- **Back-to-back accesses:** the cycle after DONE acceptance, IDLE may see a new bram_cen. Throughput is one access per 4 cycles minimum.
- **Register placement:** no combinational path from mem_* inputs to bram_stall. bram_stall depends only on state and bram_cen.

## Structure
- Shared package frv_mem_pkg holds:
  - state encoding (2-bit localparams S_IDLE=0, S_REQ=1, S_RESP=2, S_DONE=3)
  - strobe width and data width constants
- Single flat module; no sub-module warranted.

## Test plan
- **Read, zero-wait responder** (FRV BRAM adapter + BRAM model holding 0xDEADBEEF at 0x100): cen addr 0x100 wstrb 0 → mem_req in cycle 1, bram_stall high for cycles 0–2, bram_rdata = 0xDEADBEEF in cycle 4, bram_error 0.
- **Write with delays** (wstrb 4'b0101, wdata 0x11223344, addr 0x20, gnt delayed 3 cycles): mem_req held 4 cycles with mem_wen=1, mem_strb=0101, fields stable; memory bytes 0 and 2 updated.
- **Error response:** responder returns mem_error=1, rdata 0xCAFE0000 → bram_error=1 and bram_rdata=0xCAFE0000 the cycle after acceptance. The next clean read clears bram_error.
- **Abandon in DONE:** cen dropped in DONE → no acceptance, bram_rdata unchanged, FSM IDLE, next access completes normally.
- **Reset mid-operation:** g_resetn low in RESP → mem_ack=0, mem_req=0, bram_rdata=0 next cycle, state IDLE. An unsolicited mem_recv afterwards is not acked.
- **Back-to-back reads** at 0x0, 0x4, 0x8 with cen held continuously → three results in order, each 4 cycles apart.
